// File: rtl/pc_select_logic_pkg.sv
// Shared fetch-address definitions used by the fetch, decode and commit blocks.
package pc_select_logic_pkg;

  localparam int PC_MSB = 31;

  typedef logic [PC_MSB:0] addr_t;

  typedef enum logic [2:0] {
    SRC_FLUSH,
    SRC_MISDIRECT,
    SRC_JAL,
    SRC_BTB,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_select_logic_if.sv
// Next-PC select bus between the fetch control sources and the PC selector.
interface pc_select_logic_if
  import pc_select_logic_pkg::*;
#(
  parameter int WIDTH = PC_MSB
);

  logic           reset;
  logic [WIDTH:0] targetAddress;
  logic           earlyMisdirect;
  logic [WIDTH:0] decodePC;
  logic           isJAL;
  logic [WIDTH:0] validAddress;
  logic           predictorHit;
  logic [WIDTH:0] predictedPC;
  logic           validCommit;
  logic           freeze;
  logic [WIDTH:0] intermediatePC;
  logic [WIDTH:0] nextPC;
  logic           redirect;

  modport master (
    output reset, targetAddress, earlyMisdirect, decodePC, isJAL, validAddress,
           predictorHit, predictedPC, validCommit, freeze,
    input  intermediatePC, nextPC, redirect
  );

  modport slave (
    input  reset, targetAddress, earlyMisdirect, decodePC, isJAL, validAddress,
           predictorHit, predictedPC, validCommit, freeze,
    output intermediatePC, nextPC, redirect
  );

endinterface

// File: rtl/pc_select_logic_incrementer.sv
// Word-address successor; wraps silently at the top of the address space.
module pc_select_logic_incrementer #(
  parameter int WIDTH = 31
) (
  input  logic [WIDTH:0] a_i,
  output logic [WIDTH:0] y_o
);

  assign y_o = a_i + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/pc_select_logic.sv
// Fetch-stage next-PC priority select and the registered fetch PC / BTB-redirect flag.
module pc_select_logic
  import pc_select_logic_pkg::*;
#(
  parameter int WIDTH = PC_MSB
) (
  input logic              clk,
  input logic              globalReset,
  pc_select_logic_if.slave bus
);

  logic [WIDTH:0] nextpc_q, nextpc_d;
  logic           redirect_q, redirect_d;
  logic [WIDTH:0] seq_pc;
  logic [WIDTH:0] misdirect_pc;
  logic [WIDTH:0] inter_pc;
  pc_src_e        src;
  logic           unused_valid_commit;

  assign unused_valid_commit = bus.validCommit;

  pc_select_logic_incrementer #(.WIDTH(WIDTH)) u_seq_inc (
    .a_i (nextpc_q),
    .y_o (seq_pc)
  );

  pc_select_logic_incrementer #(.WIDTH(WIDTH)) u_misdirect_inc (
    .a_i (bus.decodePC),
    .y_o (misdirect_pc)
  );

  // A JAL outranks the BTB, so only an otherwise-unclaimed hit marks a redirect.
  always_comb begin
    src = SRC_SEQ;
    if (bus.reset)               src = SRC_FLUSH;
    else if (bus.earlyMisdirect) src = SRC_MISDIRECT;
    else if (bus.isJAL)          src = SRC_JAL;
    else if (bus.predictorHit)   src = SRC_BTB;
  end

  always_comb begin
    inter_pc = seq_pc;
    case (src)
      SRC_FLUSH:     inter_pc = bus.targetAddress;
      SRC_MISDIRECT: inter_pc = misdirect_pc;
      SRC_JAL:       inter_pc = bus.validAddress;
      SRC_BTB:       inter_pc = bus.predictedPC;
      default:       inter_pc = seq_pc;
    endcase
  end

  // A commit flush must land even while the pipeline is frozen.
  always_comb begin
    nextpc_d   = inter_pc;
    redirect_d = (src == SRC_BTB);
    if (bus.reset) begin
      nextpc_d   = bus.targetAddress;
      redirect_d = 1'b0;
    end else if (bus.freeze) begin
      nextpc_d   = nextpc_q;
      redirect_d = redirect_q;
    end
  end

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      nextpc_q   <= '0;
      redirect_q <= 1'b0;
    end else begin
      nextpc_q   <= nextpc_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.intermediatePC = inter_pc;
  assign bus.nextPC         = nextpc_q;
  assign bus.redirect       = redirect_q;

endmodule

// File: tb/tb_pc_select_logic.sv
// Directed bench for pc_select_logic: literal test-plan checks plus a per-cycle reference model.
module tb_pc_select_logic;

  logic clk;
  logic globalReset;
  int   checks;
  int   failures;
  bit   run_cmp;

  pc_select_logic_if #(.WIDTH(31)) bus ();

  pc_select_logic #(.WIDTH(31)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the fetch PC and redirect flag as the priority rules describe them.
  logic [31:0] m_pc;
  logic        m_redir;

  function automatic logic [31:0] m_select(input logic [31:0] pc);
    if (bus.reset)          return bus.targetAddress;
    if (bus.earlyMisdirect) return bus.decodePC + 32'd1;
    if (bus.isJAL)          return bus.validAddress;
    if (bus.predictorHit)   return bus.predictedPC;
    return pc + 32'd1;
  endfunction

  always @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      m_pc    = 32'd0;
      m_redir = 1'b0;
    end else if (bus.reset) begin
      m_pc    = bus.targetAddress;
      m_redir = 1'b0;
    end else if (!bus.freeze) begin
      m_redir = bus.predictorHit && !bus.isJAL && !bus.earlyMisdirect;
      m_pc    = m_select(m_pc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_nextPC", bus.nextPC, m_pc);
      chk("model_redirect", {31'd0, bus.redirect}, {31'd0, m_redir});
      chk("model_intermediatePC", bus.intermediatePC, m_select(m_pc));
    end
  end

  task automatic clear_inputs();
    bus.reset          = 1'b0;
    bus.targetAddress  = '0;
    bus.earlyMisdirect = 1'b0;
    bus.decodePC       = '0;
    bus.isJAL          = 1'b0;
    bus.validAddress   = '0;
    bus.predictorHit   = 1'b0;
    bus.predictedPC    = '0;
    bus.validCommit    = 1'b0;
    bus.freeze         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    run_cmp  = 1'b0;
    clear_inputs();
    globalReset = 1'b1;
    #12;
    chk("reset_nextPC", bus.nextPC, 32'd0);
    chk("reset_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("reset_intermediatePC", bus.intermediatePC, 32'd1);
    globalReset = 1'b0;
    step();
    chk("first_edge_nextPC", bus.nextPC, 32'd1);
    run_cmp = 1'b1;

    // JAL beats BTB
    clear_inputs();
    bus.isJAL = 1'b1; bus.validAddress = 32'd20;
    bus.predictorHit = 1'b1; bus.predictedPC = 32'd4;
    bus.validCommit = 1'b1;
    #1 chk("jal_inter", bus.intermediatePC, 32'd20);
    step();
    chk("jal_nextPC", bus.nextPC, 32'd20);
    chk("jal_redirect", {31'd0, bus.redirect}, 32'd0);

    // sequential
    clear_inputs();
    step();
    chk("seq_nextPC", bus.nextPC, 32'd21);
    chk("seq_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("seq_inter", bus.intermediatePC, 32'd22);

    // BTB prediction
    bus.predictorHit = 1'b1; bus.predictedPC = 32'd30;
    #1 chk("btb_inter", bus.intermediatePC, 32'd30);
    step();
    chk("btb_nextPC", bus.nextPC, 32'd30);
    chk("btb_redirect", {31'd0, bus.redirect}, 32'd1);

    // flush beats BTB
    bus.reset = 1'b1; bus.targetAddress = 32'd50;
    #1 chk("flush_inter", bus.intermediatePC, 32'd50);
    step();
    chk("flush_nextPC", bus.nextPC, 32'd50);
    chk("flush_redirect", {31'd0, bus.redirect}, 32'd0);
    clear_inputs();
    step();
    chk("post_flush_nextPC", bus.nextPC, 32'd51);
    chk("post_flush_inter", bus.intermediatePC, 32'd52);

    // freeze holds, flush overrides freeze
    bus.freeze = 1'b1; bus.predictorHit = 1'b1; bus.predictedPC = 32'd70;
    #1 chk("freeze_inter", bus.intermediatePC, 32'd70);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_hold_nextPC", bus.nextPC, 32'd51);
      chk("freeze_hold_redirect", {31'd0, bus.redirect}, 32'd0);
    end
    bus.reset = 1'b1; bus.targetAddress = 32'd90;
    step();
    chk("flush_in_freeze_nextPC", bus.nextPC, 32'd90);

    // early misdirect beats JAL
    clear_inputs();
    bus.earlyMisdirect = 1'b1; bus.decodePC = 32'd40; bus.isJAL = 1'b1; bus.validAddress = 32'd7;
    #1 chk("misdirect_inter", bus.intermediatePC, 32'd41);
    step();
    chk("misdirect_nextPC", bus.nextPC, 32'd41);
    chk("misdirect_redirect", {31'd0, bus.redirect}, 32'd0);

    // redirect held under freeze, then wrap-around
    clear_inputs();
    bus.predictorHit = 1'b1; bus.predictedPC = 32'hFFFF_FFFF;
    step();
    chk("wrap_btb_redirect", {31'd0, bus.redirect}, 32'd1);
    bus.freeze = 1'b1; bus.predictorHit = 1'b0;
    step();
    chk("freeze_redirect_held", {31'd0, bus.redirect}, 32'd1);
    chk("freeze_pc_held", bus.nextPC, 32'hFFFF_FFFF);
    bus.freeze = 1'b0;
    #1 chk("wrap_inter", bus.intermediatePC, 32'd0);
    step();
    chk("wrap_nextPC", bus.nextPC, 32'd0);
    chk("wrap_redirect", {31'd0, bus.redirect}, 32'd0);

    // asynchronous global reset mid-cycle
    bus.predictorHit = 1'b1; bus.predictedPC = 32'd123;
    step();
    chk("pre_greset_nextPC", bus.nextPC, 32'd123);
    #1 globalReset = 1'b1;
    #1;
    chk("greset_async_nextPC", bus.nextPC, 32'd0);
    chk("greset_async_redirect", {31'd0, bus.redirect}, 32'd0);
    globalReset = 1'b0;
    clear_inputs();
    step();
    chk("post_greset_nextPC", bus.nextPC, 32'd1);

    // a few mixed cycles for the model compare
    for (int i = 0; i < 16; i++) begin
      bus.reset          = (i % 7) == 3;
      bus.targetAddress  = 32'd1000 + i;
      bus.earlyMisdirect = (i % 5) == 1;
      bus.decodePC       = 32'd200 + i;
      bus.isJAL          = (i % 3) == 2;
      bus.validAddress   = 32'd300 + i;
      bus.predictorHit   = (i % 2) == 0;
      bus.predictedPC    = 32'd400 + i;
      bus.freeze         = (i % 4) == 3;
      step();
    end
    clear_inputs();
    step();
    step();
    run_cmp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
